// File: rtl/reading_window_buffer.sv
// ============================================================================
// Module   : reading_window_buffer
// Purpose  : Collects a channel-interleaved stream of signed ADC readings into
//            a CHANNELS x WINDOW matrix of 32-bit signed integers. The matrix
//            is held stable for a downstream multiplier until that consumer
//            acknowledges it. Only one frame is in flight at a time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_data      in   READING_W-bit signed reading
//   in_valid     in   in_data is valid this cycle
//   in_ready     out  a beat is accepted when in_valid && in_ready
//   mat_out      out  [channel][sample] x 32-bit signed matrix
//   out_valid    out  mat_out holds a complete frame
//   out_ack      in   consumer has finished with mat_out (honoured only
//                     while out_valid is high)
//   frame_count  out  frames released by out_ack, wraps modulo 2^16
// ----------------------------------------------------------------------------
// Optional build macro:
//   MEAN_REMOVAL_EN - keep a per-channel running sum, then spend WINDOW cycles
//                     subtracting each channel's floor mean from its row
//                     before presenting the frame. WINDOW must be a power of
//                     two in that build.
// ============================================================================
`default_nettype none

module reading_window_buffer #(
  parameter int CHANNELS  = 8,
  parameter int WINDOW    = 8,
  parameter int READING_W = 22
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [READING_W-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [CHANNELS-1:0][WINDOW-1:0][31:0] mat_out,
  output logic                                 out_valid,
  input  logic                                 out_ack,
  output logic [15:0]                          frame_count
);

  // Index widths never drop below one bit so CHANNELS=1 / WINDOW=1 still
  // build; the wrap compare then reduces to a constant true.
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SMP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(WINDOW - 1);

  localparam logic [1:0] ST_FILL   = 2'd0;
`ifdef MEAN_REMOVAL_EN
  localparam logic [1:0] ST_CENTER = 2'd1;
  localparam int         LOG2W     = $clog2(WINDOW);
`endif
  localparam logic [1:0] ST_FULL   = 2'd2;

  logic [1:0]                            state_q, state_d;
  logic [CH_W-1:0]                       ch_idx_q, ch_idx_d;
  logic [SMP_W-1:0]                      smp_idx_q, smp_idx_d;
  logic [CHANNELS-1:0][WINDOW-1:0][31:0] mat_q, mat_d;
  logic [15:0]                           frame_count_q, frame_count_d;

  logic        accept;
  logic        last_ch;
  logic        last_smp;
  logic        release_frame;
  logic [31:0] ext_val;

  assign accept        = in_valid && in_ready;
  assign last_ch       = (ch_idx_q == LAST_CH);
  assign last_smp      = (smp_idx_q == LAST_SMP);
  assign release_frame = (state_q == ST_FULL) && out_ack;
  assign ext_val       = 32'($signed(in_data));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (accept && last_ch && last_smp) begin
`ifdef MEAN_REMOVAL_EN
          state_d = ST_CENTER;
`else
          state_d = ST_FULL;
`endif
        end
      end
`ifdef MEAN_REMOVAL_EN
      ST_CENTER: begin
        // smp_idx doubles as the column counter for the centring pass.
        if (last_smp) begin
          state_d = ST_FULL;
        end
      end
`endif
      ST_FULL: begin
        if (out_ack) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. in_ready is also gated by rst_n so it reads 0 for the whole
  // time reset is asserted, not only after the first clock.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = rst_n && (state_q == ST_FILL);
    out_valid = (state_q == ST_FULL);
  end

  // --------------------------------------------------------------------------
  // Write indices: channel-minor, sample-major.
  // --------------------------------------------------------------------------
  always_comb begin
    ch_idx_d  = ch_idx_q;
    smp_idx_d = smp_idx_q;
    if (accept) begin
      if (last_ch) begin
        ch_idx_d  = '0;
        smp_idx_d = last_smp ? '0 : smp_idx_q + SMP_W'(1);
      end else begin
        ch_idx_d  = ch_idx_q + CH_W'(1);
      end
    end
`ifdef MEAN_REMOVAL_EN
    else if (state_q == ST_CENTER) begin
      smp_idx_d = last_smp ? '0 : smp_idx_q + SMP_W'(1);
    end
`endif
  end

`ifdef MEAN_REMOVAL_EN
  // --------------------------------------------------------------------------
  // Per-channel running sums and their floor means.
  // --------------------------------------------------------------------------
  logic signed [39:0] acc_q [CHANNELS];
  logic signed [39:0] acc_d [CHANNELS];
  logic        [31:0] mean  [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      // Arithmetic shift floors toward -inf; the mean of 22-bit readings
      // always fits in 32 bits.
      mean[c] = 32'(acc_q[c] >>> LOG2W);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (release_frame) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = '0;
      end
    end else if (accept) begin
      acc_d[ch_idx_q] = acc_q[ch_idx_q] + 40'($signed(in_data));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Matrix storage.
  // --------------------------------------------------------------------------
  always_comb begin
    mat_d = mat_q;
    if (accept) begin
      mat_d[ch_idx_q][smp_idx_q] = ext_val;
    end
`ifdef MEAN_REMOVAL_EN
    if (state_q == ST_CENTER) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mat_d[c][smp_idx_q] = mat_q[c][smp_idx_q] - mean[c];
      end
    end
`endif
  end

  always_comb begin
    frame_count_d = frame_count_q;
    if (release_frame) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx_q      <= '0;
      smp_idx_q     <= '0;
      mat_q         <= '0;
      frame_count_q <= '0;
    end else begin
      ch_idx_q      <= ch_idx_d;
      smp_idx_q     <= smp_idx_d;
      mat_q         <= mat_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign mat_out     = mat_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_reading_window_buffer.sv
// ============================================================================
// Module   : tb_reading_window_buffer
// Purpose  : Self-checking bench for reading_window_buffer with CHANNELS=2,
//            WINDOW=4. Beats come from a table of {reading, sign-extended
//            value}; each completed frame is predicted by a small model and
//            queued, then popped and compared when out_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reading_window_buffer;

  localparam int CH    = 2;
  localparam int WN    = 4;
  localparam int RW    = 22;
  localparam int LOG2W = 2;

`ifdef MEAN_REMOVAL_EN
  localparam bit MEAN_EN = 1'b1;
  localparam int EXP_LAT = WN + 1;
`else
  localparam bit MEAN_EN = 1'b0;
  localparam int EXP_LAT = 1;
`endif

  typedef logic [CH-1:0][WN-1:0][31:0] frame_t;
  typedef struct {
    logic [RW-1:0] din;
    logic [31:0]   raw;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  frame_t        mat_out;
  logic          out_valid;
  logic          out_ack = 1'b0;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  reading_window_buffer #(
    .CHANNELS  (CH),
    .WINDOW    (WN),
    .READING_W (RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mat_out     (mat_out),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .frame_count (frame_count)
  );

  vec_t   tbl [32];
  frame_t exp_q [$];
  frame_t last_exp;
  int     n_vec = 0;
  int     n_err = 0;

  // Reference model state
  frame_t             m_frame;
  logic signed [39:0] m_sum [CH];
  int                 m_ch;
  int                 m_smp;
  int                 m_fc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_frame = '0;
    for (int c = 0; c < CH; c++) m_sum[c] = '0;
    m_ch  = 0;
    m_smp = 0;
  endtask

  task automatic model_push(input logic [31:0] raw);
    frame_t             e;
    logic signed [39:0] mean;
    m_frame[m_ch][m_smp] = raw;
    m_sum[m_ch] = m_sum[m_ch] + 40'($signed(raw));
    m_ch++;
    if (m_ch == CH) begin
      m_ch = 0;
      m_smp++;
    end
    if (m_smp == WN) begin
      e = m_frame;
      for (int c = 0; c < CH; c++) begin
        mean = m_sum[c] >>> LOG2W;
        if (MEAN_EN) begin
          for (int s = 0; s < WN; s++) e[c][s] = m_frame[c][s] - mean[31:0];
        end
      end
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [RW-1:0] din, input logic [31:0] raw, input bit push);
    int w = 0;
    in_data  = din;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept: in_ready stayed %0b, required 1", in_ready);
    end else if (push) begin
      model_push(raw);
    end
    step();
    in_valid = 1'b0;
    in_data  = RW'($urandom);
  endtask

  // Called right after the final beat's accepting edge.
  task automatic expect_frame(input string name);
    int     w = 0;
    frame_t e;
    while (!out_valid && w < 100) begin
      step();
      w++;
    end
    check({name, "_latency"}, w + 1, EXP_LAT);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_queue: no expected frame queued, required 1", name);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check({name, "_mat"}, mat_out, e);
    end
    check({name, "_in_ready_full"}, in_ready, 1'b0);
  endtask

  task automatic do_ack(input string name);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    m_fc++;
    check({name, "_out_valid"}, out_valid, 1'b0);
    check({name, "_frame_count"}, frame_count, 16'(m_fc));
    check({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_in_ready"}, in_ready, 1'b0);
    check({name, "_out_valid"}, out_valid, 1'b0);
    check({name, "_frame_count"}, frame_count, 16'd0);
    check({name, "_mat"}, mat_out, '0);
  endtask

  initial begin
    // f0: 1..8
    for (int i = 0; i < 8; i++) tbl[i] = '{RW'(i + 1), 32'(i + 1)};
    // f1: range edges
    tbl[8]  = '{22'h3FFFFF, 32'hFFFFFFFF};
    tbl[9]  = '{22'h200000, 32'hFFE00000};
    tbl[10] = '{22'h1FFFFF, 32'h001FFFFF};
    tbl[11] = '{22'h000000, 32'h00000000};
    tbl[12] = '{22'h3FFFFE, 32'hFFFFFFFE};
    tbl[13] = '{22'h000007, 32'h00000007};
    tbl[14] = '{22'h2AAAAA, 32'hFFEAAAAA};
    tbl[15] = '{22'h155555, 32'h00155555};
    // f2: 100, 200, ... 800
    for (int i = 0; i < 8; i++) tbl[16 + i] = '{RW'(100 * (i + 1)), 32'(100 * (i + 1))};
    // f3: mixed signs
    tbl[24] = '{22'h3FFF00, 32'hFFFFFF00};
    tbl[25] = '{22'd10,     32'd10};
    tbl[26] = '{22'd20,     32'd20};
    tbl[27] = '{22'h3FFFE2, 32'hFFFFFFE2};
    tbl[28] = '{22'd40,     32'd40};
    tbl[29] = '{22'd50,     32'd50};
    tbl[30] = '{22'd60,     32'd60};
    tbl[31] = '{22'd70,     32'd70};

    model_clear();
    m_fc = 0;

    // Reset state
    #1;
    check_reset("reset");
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    // Frame 0: continuous stream 1..8
    for (int i = 0; i < 8; i++) send_beat(tbl[i].din, tbl[i].raw, 1'b1);
    expect_frame("f0");

    // Hold off the ack with in_valid asserted: nothing may change
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = RW'($urandom);
      #1;
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_mat", mat_out, last_exp);
      step();
    end
    check("hold_out_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    do_ack("ack0");

    // Frame 1: range edges; the first beat lands in [0][0]
    for (int i = 8; i < 16; i++) send_beat(tbl[i].din, tbl[i].raw, 1'b1);
    expect_frame("f1");
    do_ack("ack1");

    // Reset after 5 beats of a frame
    for (int i = 16; i < 21; i++) send_beat(tbl[i].din, tbl[i].raw, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    model_clear();
    exp_q.delete();
    m_fc = 0;
    step();
    step();
    rst_n = 1'b1;
    #1;

    // Gapped stream with spurious acks while out_valid is low
    for (int i = 0; i < 8; i++) begin
      send_beat(tbl[24 + i].din, tbl[24 + i].raw, 1'b1);
      if (i != 7) begin
        in_valid = 1'b0;
        in_data  = RW'($urandom);
        out_ack  = (i == 1 || i == 4);
        step();
        out_ack  = 1'b0;
      end
    end
    expect_frame("f3_gapped");
    check("spurious_ack_frame_count", frame_count, 16'd0);
    do_ack("ack3");

    // Frame 2 after reset recovery
    for (int i = 16; i < 24; i++) send_beat(tbl[i].din, tbl[i].raw, 1'b1);
    expect_frame("f2");
    do_ack("ack2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reading_window_buffer.md
Name: reading_window_buffer

Overview:
- Upstream feeder for the matrix-multiply stage in the fetal ECG pipeline.
- Accepts a stream of 22-bit two's-complement ADC readings, channel-interleaved, one reading per beat.
- Assembles them into a CHANNELS x WINDOW signed-integer matrix and holds it stable for the downstream multiplier, for example for an X*X^T covariance product.
- Frame-level valid/ack handshake: one matrix is in flight at a time.

Parameters:
- CHANNELS, 8, number of electrode channels; rows of mat_out; >=1.
- WINDOW, 8, samples per channel per frame; columns of mat_out; >=1; must be a power of two when MEAN_REMOVAL_EN is defined.
- READING_W, 22, input reading width, signed two's complement; <=32.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_data  in  READING_W  signed reading.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- mat_out  out  CHANNELS x WINDOW x 32  integer matrix [channel][sample], signed.
- out_valid  out  1  mat_out holds a complete frame.
- out_ack  in  1  consumer has finished with mat_out.
- frame_count  out  16  number of frames released by out_ack; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous on rst_n low): state=FILL, ch_idx=0, smp_idx=0, every mat_out element=0, out_valid=0, in_ready=0 while rst_n is low, frame_count=0. Reset mid-fill or mid-hold discards the partial or held frame.
- States: FILL, CENTER (only with MEAN_REMOVAL_EN), FULL.
- Every state other than FILL holds in_ready=0.
- FILL:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - An accepted beat writes sign_extend(in_data) to element [ch_idx][smp_idx].
  - Order is sample-major, channel-minor: ch_idx increments each beat. When ch_idx wraps from CHANNELS-1 to 0, smp_idx increments.
  - The beat that writes [CHANNELS-1][WINDOW-1] moves the state to FULL (or CENTER), resets both indices to 0 and drops in_ready on the next cycle.
- FULL:
  - out_valid=1 and mat_out is frozen; in_data is ignored.
  - out_ack=1 in FULL: next cycle out_valid=0, state=FILL, frame_count+=1.
  - The first new beat can be accepted in the cycle after the ack.
- out_ack while out_valid=0 is ignored.
- Without MEAN_REMOVAL_EN, out_valid rises in the cycle after the final accepted beat (latency 1).
- in_valid with no accept: no state change and no write.
- mat_out elements outside FULL are undefined for the consumer and are qualified only by out_valid.
- Arithmetic: the 22-bit reading is sign-extended to 32 bits. No saturation is needed: the 22-bit range fits.
- CHANNELS=1 or WINDOW=1 must work. The index wrap logic must not depend on a width greater than 1.

Optional Feature:
- Macro: MEAN_REMOVAL_EN.
- Defined:
  - One signed 40-bit accumulator per channel, cleared on reset and on entering FILL.
  - Each accepted beat adds its value to acc[ch_idx].
  - After the final beat the state enters CENTER for exactly WINDOW cycles.
  - Cycle s subtracts mean[c] = acc[c] >>> log2(WINDOW) (arithmetic shift, floor) from column s of every channel.
  - Then the state enters FULL, so out_valid rises WINDOW+1 cycles after the final beat.
  - Reset during CENTER discards the frame.
- Undefined: no accumulators and no CENTER state; raw sign-extended readings; latency 1.

Test Plan:
- CHANNELS=2, WINDOW=4. Stream 1..8 continuously -> out_valid rises 1 cycle after the 8th beat; mat_out[0]={1,3,5,7}, mat_out[1]={2,4,6,8}; in_ready=0 in FULL.
- Feed in_data=22'h3FFFFF (-1) and 22'h200000 (-2097152) -> elements read 32'hFFFFFFFF and -2097152.
- Hold out_ack=0 for 20 cycles with in_valid=1 -> mat_out unchanged, no beat accepted. Then pulse out_ack -> out_valid=0 next cycle, frame_count=1, and the next beat is written to [0][0].
- Assert rst_n=0 after 5 of 8 beats -> all outputs return to reset values. Then 8 new beats -> a correct frame built from the new beats only.
- Toggle in_valid 1,0,1,0... and pulse out_ack while out_valid=0 -> only valid beats are written; the spurious ack has no effect; frame_count stays 0.
- With MEAN_REMOVAL_EN, CHANNELS=2, WINDOW=4, input 1..8 -> out_valid rises 5 cycles after the last beat. Means are floor(16/4)=4 and 5, giving mat_out[0]={-3,-1,1,3} and mat_out[1]={-3,-1,1,3}.
